// File: rtl/reorder_logic_pkg.sv
// Shared definitions for the reorder/trace path: default sizing, dispatcher
// state encoding and micro-op count clamping.
package reorder_logic_pkg;

    localparam int   DEF_NUM_QUEUES   = 8;
    localparam int   DEF_DEPTH        = 64;
    localparam int   DEF_MAX_UOPS     = 8;
    localparam logic DEF_BREAKPOINT   = 1'b1;
    localparam int   DEF_MAX_DEADLOCK = 2000;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } dispatch_state_e;

    // A zero count still issues one micro-op; oversize counts saturate.
    function automatic int unsigned clamp_uops(input int unsigned raw,
                                               input int unsigned max_uops);
        if (raw == 0) begin
            return 1;
        end
        if (raw > max_uops) begin
            return max_uops;
        end
        return raw;
    endfunction

endpackage

// File: rtl/trace_dispatch_if.sv
// Instruction-in / trace-out bundle of the trace dispatcher. The master side
// offers instructions and reports reorder backpressure; the slave side issues.
interface trace_dispatch_if import reorder_logic_pkg::*; #(
    parameter int NUM_QUEUES = DEF_NUM_QUEUES,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int MAX_UOPS   = DEF_MAX_UOPS
) ();

    localparam int ID_WIDTH  = $clog2(DEPTH);
    localparam int CNT_WIDTH = $clog2(MAX_UOPS) + 1;
    localparam int SEL_WIDTH = $clog2(NUM_QUEUES);

    logic                          instr_valid_i;
    logic                          instr_ready_o;
    logic [ID_WIDTH-1:0]           instr_id_i;
    logic [CNT_WIDTH-1:0]          instr_count_i;
    logic [MAX_UOPS*SEL_WIDTH-1:0] instr_sel_i;
    logic                          full_i;

    logic                          trace_push_o;
    logic [SEL_WIDTH-1:0]          trace_sel_o;
    logic                          trace_break_o;
    logic                          trace_id_push_o;
    logic [ID_WIDTH-1:0]           trace_id_value_o;

    modport master (
        output instr_valid_i, instr_id_i, instr_count_i, instr_sel_i, full_i,
        input  instr_ready_o, trace_push_o, trace_sel_o, trace_break_o,
               trace_id_push_o, trace_id_value_o
    );

    modport slave (
        input  instr_valid_i, instr_id_i, instr_count_i, instr_sel_i, full_i,
        output instr_ready_o, trace_push_o, trace_sel_o, trace_break_o,
               trace_id_push_o, trace_id_value_o
    );

endinterface

// File: rtl/trace_dispatch_watchdog.sv
// Stall watchdog for the trace dispatcher (built only with
// TRACE_DISPATCH_DEADLOCK_EN): raises a sticky alarm after MAX_DEADLOCK stalls.
module dispatch_watchdog import reorder_logic_pkg::*; #(
    parameter int MAX_DEADLOCK = DEF_MAX_DEADLOCK
) (
    input  logic clk_i,
    input  logic ars_i,
    input  logic stall_i,
    output logic deadlock_o
);

    localparam int CW = $clog2(MAX_DEADLOCK + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_DEADLOCK);

    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic          alarm_q, alarm_d;

    // Any non-stall cycle (a push or idle) restarts the run; count saturates.
    always_comb begin
        stall_cnt_d = '0;
        alarm_d     = alarm_q;
        if (stall_i) begin
            stall_cnt_d = (stall_cnt_q == LIMIT) ? stall_cnt_q
                                                 : stall_cnt_q + CW'(1);
        end
        if (stall_cnt_d == LIMIT) begin
            alarm_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge ars_i) begin
        if (ars_i) begin
            stall_cnt_q <= '0;
            alarm_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            alarm_q     <= alarm_d;
        end
    end

    assign deadlock_o = alarm_q;

endmodule

// File: rtl/trace_dispatch.sv
// Trace dispatcher: accepts one instruction at a time and pushes its micro-ops
// into the reorder trace port. Optional stall alarm via TRACE_DISPATCH_DEADLOCK_EN.
//
// state    | meaning
// ST_IDLE  | ready for a new instruction, trace outputs quiet
// ST_ISSUE | pushing micro-ops of the held instruction, one per unstalled cycle
module trace_dispatch import reorder_logic_pkg::*; #(
    parameter int   NUM_QUEUES   = DEF_NUM_QUEUES,
    parameter int   DEPTH        = DEF_DEPTH,
    parameter int   MAX_UOPS     = DEF_MAX_UOPS,
    parameter logic BREAKPOINT   = DEF_BREAKPOINT,
    parameter int   MAX_DEADLOCK = DEF_MAX_DEADLOCK
) (
    input  logic             clk_i,
    input  logic             ars_i,
    trace_dispatch_if.slave  bus
`ifdef TRACE_DISPATCH_DEADLOCK_EN
    ,
    output logic             deadlock_o
`endif
);

    localparam int ID_WIDTH  = $clog2(DEPTH);
    localparam int CNT_WIDTH = $clog2(MAX_UOPS) + 1;
    localparam int SEL_WIDTH = $clog2(NUM_QUEUES);

    dispatch_state_e               state_q, state_d;
    logic [ID_WIDTH-1:0]           id_q, id_d;
    logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]          idx_q, idx_d;
    logic [MAX_UOPS*SEL_WIDTH-1:0] sel_q, sel_d;

    logic                 issue;
    logic                 ready;
    logic                 accept;
    logic                 last_uop;
    logic                 push;
    logic [SEL_WIDTH-1:0] cur_sel;

    assign issue    = (state_q == ST_ISSUE);
    // Ready is withheld while reset is asserted so nothing is accepted then.
    assign ready    = (state_q == ST_IDLE) & ~ars_i;
    assign accept   = bus.instr_valid_i & ready;
    assign last_uop = (idx_q == cnt_q - CNT_WIDTH'(1));
    assign push     = issue & ~bus.full_i;

    always_comb begin
        cur_sel = '0;
        for (int k = 0; k < MAX_UOPS; k++) begin
            if (idx_q == CNT_WIDTH'(k)) begin
                cur_sel = sel_q[k*SEL_WIDTH +: SEL_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d    = bus.instr_id_i;
                    sel_d   = bus.instr_sel_i;
                    cnt_d   = CNT_WIDTH'(clamp_uops(32'(bus.instr_count_i), MAX_UOPS));
                    idx_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Stalled cycles fall through with everything held.
                if (push) begin
                    if (last_uop) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge ars_i) begin
        if (ars_i) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.instr_ready_o    = ready;
    assign bus.trace_push_o     = push;
    assign bus.trace_sel_o      = issue ? cur_sel : '0;
    assign bus.trace_break_o    = issue & (last_uop ? BREAKPOINT : ~BREAKPOINT);
    assign bus.trace_id_push_o  = push & last_uop;
    assign bus.trace_id_value_o = issue ? id_q : '0;

`ifdef TRACE_DISPATCH_DEADLOCK_EN
    dispatch_watchdog #(
        .MAX_DEADLOCK (MAX_DEADLOCK)
    ) u_watchdog (
        .clk_i      (clk_i),
        .ars_i      (ars_i),
        .stall_i    (issue & bus.full_i),
        .deadlock_o (deadlock_o)
    );
`endif

endmodule

// File: tb/tb_trace_dispatch.sv
// Scoreboard bench for trace_dispatch: expected pushes are queued at acceptance
// and matched against the trace port on every falling clock edge.
module tb_trace_dispatch;
    import reorder_logic_pkg::*;

    localparam int   NQ = 8;
    localparam int   DP = 64;
    localparam int   MU = 8;
    localparam logic BP = 1'b1;
    localparam int   SW = 3;
    localparam int   IW = 6;
    localparam int   CW = 4;

    typedef struct packed {
        logic [SW-1:0] sel;
        logic          brk;
        logic          idp;
        logic [IW-1:0] idv;
    } push_t;

    logic clk = 1'b0;
    logic ars;
    always #5 clk = ~clk;

    trace_dispatch_if #(.NUM_QUEUES(NQ), .DEPTH(DP), .MAX_UOPS(MU)) bus ();

`ifdef TRACE_DISPATCH_DEADLOCK_EN
    logic deadlock;
`endif

    trace_dispatch #(
        .NUM_QUEUES (NQ),
        .DEPTH      (DP),
        .MAX_UOPS   (MU),
        .BREAKPOINT (BP),
        .MAX_DEADLOCK (2000)
    ) dut (
        .clk_i (clk),
        .ars_i (ars),
        .bus   (bus)
`ifdef TRACE_DISPATCH_DEADLOCK_EN
        ,
        .deadlock_o (deadlock)
`endif
    );

    push_t exp_q[$];
    int    idp_cyc[$];
    int    n_vec    = 0;
    int    n_err    = 0;
    int    cyc      = 0;
    int    push_cnt = 0;
    push_t got_p;
    push_t exp_p;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!ars) begin
            if (bus.trace_push_o) begin
                push_cnt++;
                got_p = '{sel: bus.trace_sel_o, brk: bus.trace_break_o,
                          idp: bus.trace_id_push_o, idv: bus.trace_id_value_o};
                if (bus.trace_id_push_o) idp_cyc.push_back(cyc);
                check_val("push_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_p = exp_q.pop_front();
                    check_val("push", 32'(got_p), 32'(exp_p));
                end
                check_val("push_while_full", 32'(bus.full_i), 0);
            end else if (bus.instr_ready_o) begin
                check_val("idle_quiet", {bus.trace_sel_o, bus.trace_break_o,
                          bus.trace_id_push_o, bus.trace_id_value_o}, 0);
            end else begin
                check_val("stall_no_idpush", 32'(bus.trace_id_push_o), 0);
            end
        end
    end

    task automatic send(input int id, input int cnt, input logic [MU*SW-1:0] sel);
        int n;
        int t;
        n = (cnt == 0) ? 1 : ((cnt > MU) ? MU : cnt);
        @(negedge clk);
        bus.instr_valid_i = 1'b1;
        bus.instr_id_i    = IW'(id);
        bus.instr_count_i = CW'(cnt);
        bus.instr_sel_i   = sel;
        t = 0;
        while (!bus.instr_ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_val("accept_in_time", 32'(t < 200), 1);
        @(posedge clk);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{sel: sel[k*SW +: SW], brk: (k == n-1) ? BP : ~BP,
                              idp: (k == n-1), idv: IW'(id)});
        end
        #1;
        bus.instr_valid_i = 1'b0;
        bus.instr_id_i    = IW'($urandom);
        bus.instr_count_i = CW'($urandom);
        bus.instr_sel_i   = 24'($urandom);
    endtask

    task automatic drain(output int cycles, input bit rand_full);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 500) begin
            if (rand_full) begin
                @(posedge clk);
                #1 bus.full_i = ($urandom_range(0, 2) == 0);
            end
            @(negedge clk);
            #1;
            cycles++;
        end
        bus.full_i = 1'b0;
        check_val("drain_complete", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [MU*SW-1:0] s;
        logic [MU*SW-1:0] s2;
        int c;
        int p0;
        int p1;
        int i0;

        ars = 1'b1;
        bus.instr_valid_i = 1'b0;
        bus.instr_id_i    = '0;
        bus.instr_count_i = '0;
        bus.instr_sel_i   = '0;
        bus.full_i        = 1'b0;
        #1;
        check_val("rst_ready_low", 32'(bus.instr_ready_o), 0);
        check_val("rst_outputs", {bus.trace_push_o, bus.trace_sel_o, bus.trace_break_o,
                  bus.trace_id_push_o, bus.trace_id_value_o}, 0);
        repeat (3) @(negedge clk);
        ars = 1'b0;
        @(negedge clk);
        #1;
        check_val("ready_after_rst", 32'(bus.instr_ready_o), 1);

        // Three micro-ops, selectors 0,7,2, no backpressure.
        s = '0;
        s[2:0] = 3'd0;
        s[5:3] = 3'd7;
        s[8:6] = 3'd2;
        send(5, 3, s);
        drain(c, 1'b0);
        check_val("t1_push_cycles", c, 3);
        check_val("t1_busy_on_last", 32'(bus.instr_ready_o), 0);
        @(negedge clk);
        #1;
        check_val("t1_ready_next", 32'(bus.instr_ready_o), 1);

        // Zero count issues a single micro-op.
        p0 = push_cnt;
        s = 24'($urandom);
        s[2:0] = 3'd4;
        send(11, 0, s);
        drain(c, 1'b0);
        check_val("t2_one_push", push_cnt - p0, 1);

        // Oversize count saturates at MAX_UOPS.
        p0 = push_cnt;
        send(33, 12, 24'($urandom));
        drain(c, 1'b0);
        check_val("t2b_clamped", push_cnt - p0, MU);

        // Backpressure after the first push.
        p0 = push_cnt;
        send(20, 4, 24'($urandom));
        @(negedge clk);
        #1;
        check_val("t3_first_push", push_cnt - p0, 1);
        @(posedge clk);
        #1 bus.full_i = 1'b1;
        p1 = push_cnt;
        repeat (10) @(posedge clk);
        check_val("t3_no_push_stalled", push_cnt, p1);
        #1 bus.full_i = 1'b0;
        drain(c, 1'b0);
        check_val("t3_total_pushes", push_cnt - p0, 4);

        // Reset during the second of five micro-ops.
        i0 = idp_cyc.size();
        send(40, 5, 24'($urandom));
        @(negedge clk);
        @(posedge clk);
        #2 ars = 1'b1;
        #1;
        check_val("t4_rst_outputs", {bus.instr_ready_o, bus.trace_push_o, bus.trace_sel_o,
                  bus.trace_break_o, bus.trace_id_push_o, bus.trace_id_value_o}, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        ars = 1'b0;
        check_val("t4_no_idpush", idp_cyc.size() - i0, 0);
        @(negedge clk);
        #1;
        check_val("t4_ready_after", 32'(bus.instr_ready_o), 1);
        send(9, 1, 24'($urandom));
        drain(c, 1'b0);
        check_val("t4_next_one_push", c, 1);

        // Back-to-back full-length instructions.
        p0 = push_cnt;
        i0 = idp_cyc.size();
        s  = 24'($urandom);
        s2 = 24'($urandom);
        send(62, 8, s);
        send(63, 8, s2);
        drain(c, 1'b0);
        check_val("t5_pushes", push_cnt - p0, 16);
        check_val("t5_idp_count", idp_cyc.size() - i0, 2);
        if (idp_cyc.size() - i0 == 2) begin
            check_val("t5_bubble", idp_cyc[i0+1] - idp_cyc[i0], 9);
        end

        // Random instructions under random backpressure.
        for (int r = 0; r < 8; r++) begin
            p0 = push_cnt;
            c  = $urandom_range(0, 10);
            p1 = (c == 0) ? 1 : ((c > MU) ? MU : c);
            send($urandom_range(0, DP-1), c, 24'($urandom));
            drain(c, 1'b1);
            check_val("rand_pushes", push_cnt - p0, p1);
        end

`ifdef TRACE_DISPATCH_DEADLOCK_EN
        check_val("wd_idle_low", 32'(deadlock), 0);
        bus.full_i = 1'b1;
        send(3, 2, 24'($urandom));
        repeat (2000) @(negedge clk);
        check_val("wd_before_limit", 32'(deadlock), 0);
        @(negedge clk);
        check_val("wd_at_limit", 32'(deadlock), 1);
        #1 bus.full_i = 1'b0;
        drain(c, 1'b0);
        @(negedge clk);
        check_val("wd_sticky", 32'(deadlock), 1);
        ars = 1'b1;
        #1;
        check_val("wd_cleared_by_rst", 32'(deadlock), 0);
        @(negedge clk);
        ars = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trace_dispatch.md
TRACE_DISPATCH -- requirements
Module: trace_dispatch

Interface
REQ-001 SHALL have parameter NUM_QUEUES, default 8, number of execution queues.
REQ-002 SHALL have parameter DEPTH, default 64, reorder entries; ID_WIDTH = $clog2(DEPTH).
REQ-003 SHALL have parameter MAX_UOPS, default 8, maximum micro-ops per instruction; CNT_WIDTH = $clog2(MAX_UOPS)+1.
REQ-004 SHALL have parameter BREAKPOINT, default 1'b1, trace breakpoint value; SEL_WIDTH = $clog2(NUM_QUEUES).
REQ-005 SHALL have parameter MAX_DEADLOCK, default 2000, stall-cycle limit (used only with the REQ-025 macro).
REQ-006 clk_i  input  1  clock; one clock domain.
REQ-007 ars_i  input  1  reset, asynchronous, active-high.
REQ-008 instr_valid_i  input  1  instruction offered.
REQ-009 instr_ready_o  output  1  instruction accepted when valid and ready.
REQ-010 instr_id_i  input  ID_WIDTH  instruction ID.
REQ-011 instr_count_i  input  CNT_WIDTH  micro-op count.
REQ-012 instr_sel_i  input  MAX_UOPS*SEL_WIDTH  packed queue selectors; micro-op k in bits [k*SEL_WIDTH +: SEL_WIDTH].
REQ-013 full_i  input  1  reorder logic full; backpressure.
REQ-014 trace_push_o, trace_sel_o (SEL_WIDTH), trace_break_o, trace_id_push_o, trace_id_value_o (ID_WIDTH)  outputs  trace interface into reorder_logic_top.
REQ-015 deadlock_o  output  1  sticky stall alarm; exists only with the REQ-025 macro.

Function
REQ-016 SHALL implement FSM IDLE and ISSUE; instr_ready_o = (state==IDLE).
REQ-017 IDLE: on instr_valid_i & instr_ready_o, SHALL register ID, selectors and count, clamping count 0 to 1 and counts > MAX_UOPS to MAX_UOPS, clear uop index, and go to ISSUE.
REQ-018 ISSUE: trace_push_o = ~full_i (combinational); trace_sel_o = stored selector[index]; trace_id_value_o = stored ID.
REQ-019 Non-last micro-op: trace_break_o = ~BREAKPOINT, trace_id_push_o = 0; on push, index increments.
REQ-020 Last micro-op (index == count-1): trace_break_o = BREAKPOINT and trace_id_push_o = trace_push_o; on push, FSM returns to IDLE.
REQ-021 While full_i is high, SHALL hold index, selector, and state, with zero pushes; resume the cycle full_i drops.
REQ-022 Latency: acceptance at edge N gives the first push in cycle N+1; an instruction of n micro-ops with no stalls takes n ISSUE cycles plus 1 IDLE cycle before the next acceptance.
REQ-023 In IDLE, all trace_* outputs are 0; inputs are ignored except on acceptance.

Reset
REQ-024 ars_i high SHALL immediately force IDLE, index 0, stored registers 0, all outputs 0 (instr_ready_o 1 after release); any in-flight instruction is dropped without a partial id push.

Configuration
REQ-025 Macro TRACE_DISPATCH_DEADLOCK_EN: when defined, a counter increments each ISSUE cycle with full_i high and clears on any push or in IDLE; reaching MAX_DEADLOCK sets deadlock_o, which stays set until reset. When undefined, there is no counter and no deadlock_o port, and behaviour is otherwise identical.

Structure
REQ-026 SHALL place the FSM state encoding constants and default parameter values (NUM_QUEUES, DEPTH, MAX_UOPS, BREAKPOINT) in the shared package reorder_logic_pkg.
REQ-027 The deadlock counter SHALL be the sub-module dispatch_watchdog, instantiated only under TRACE_DISPATCH_DEADLOCK_EN; all other logic is inline.

Verification
REQ-028 id=5, count=3, sel={2,7,0} (uop0=0), full_i=0: pushes with sel 0,7,2 in 3 consecutive cycles; break and id_push only on the third push, with value 5; ready high again the next cycle.
REQ-029 count=0, sel[0]=4: exactly one push, sel 4, break=BREAKPOINT, id_push=1.
REQ-030 count=4, full_i high for 10 cycles after the first push: exactly 4 pushes in total, sel order preserved, no pushes while full_i is high.
REQ-031 ars_i asserted during the second of 5 micro-ops: outputs 0 the same cycle, no id_push; after release, the next instruction id=9, count=1 issues normally.
REQ-032 Back-to-back instructions id=62 and id=63, count=8 each: 16 pushes, one IDLE bubble between them, id_push values 62 then 63.
REQ-033 With TRACE_DISPATCH_DEADLOCK_EN and full_i held high for 2000 ISSUE cycles: deadlock_o rises, stays high after full_i drops, and clears only on ars_i.
